cla_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder with valid/ready handshaking. It replaces the fixed 32-bit combinational adder. Operand width and pipeline depth are set by parameters. The carry ripples between 8-bit lookahead groups and is registered at stage boundaries, so one add issues per cycle at the target clock. It sits between operand-read and writeback in the ALU path and accepts backpressure from downstream.

---
 rtl/cla_pkg.sv | 28 ++
 rtl/cla_group8.sv | 31 +++
 rtl/cla_pipe.sv | 153 +++++++++++++++
 tb/tb_cla_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group width,
// the per-stage pipeline register layout and the parameter legality check.
package cla_pkg;

  localparam int unsigned GROUP_W = 8;
  // Widest supported operand; stage registers are sized for it and the
  // unused upper bits stay at their reset value of zero.
  localparam int unsigned MAX_W   = 128;

  typedef struct packed {
    logic             valid;
    logic             carry;  // carry out of this stage's slice
    logic             msb_c;  // carry into this stage's slice MSB
    logic [MAX_W-1:0] sum;    // completed sum bits up to this stage
    logic [MAX_W-1:0] a;      // operand bits still to be consumed
    logic [MAX_W-1:0] b;
  } cla_stage_t;

  // Width a multiple of the group size within range, stage count dividing
  // the number of groups.
  function automatic bit cla_params_ok(int unsigned width, int unsigned stages);
    int unsigned groups;
    groups = width / GROUP_W;
    return (width % GROUP_W == 0) && (width >= GROUP_W) && (width <= MAX_W) &&
           (stages >= 1) && (stages <= groups) && (groups % stages == 0);
  endfunction

endpackage

// File: rtl/cla_group8.sv
// Combinational 8-bit carry-lookahead group: internal carries c[8:1] plus
// group generate/propagate for chaining to the next group.
module cla_group8 (
  input  logic [7:0] g_i,
  input  logic [7:0] p_i,
  input  logic       cin_i,
  output logic [8:1] c_o,
  output logic       gg_o,
  output logic       gp_o
);

  logic [7:0] pre_g;
  logic [7:0] pre_p;

  // Prefix generate/propagate over bits [i:0]; flattened by synthesis.
  always_comb begin
    pre_g    = '0;
    pre_p    = '0;
    pre_g[0] = g_i[0];
    pre_p[0] = p_i[0];
    for (int i = 1; i < 8; i++) begin
      pre_g[i] = g_i[i] | (p_i[i] & pre_g[i-1]);
      pre_p[i] = p_i[i] & pre_p[i-1];
    end
  end

  assign c_o  = pre_g | (pre_p & {8{cin_i}});
  assign gg_o = pre_g[7];
  assign gp_o = pre_p[7];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder with elastic valid/ready stages.
// Optional subtract support is compiled in with CLA_PIPE_SUB_EN.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic             in_cin_i,
`ifdef CLA_PIPE_SUB_EN
  input  logic             in_sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_cout_o,
  output logic             out_ovf_o
);

  localparam int unsigned NG  = WIDTH / GROUP_W;
  localparam int unsigned GPS = NG / STAGES;

  if (!cla_params_ok(WIDTH, STAGES)) begin : gen_bad_params
    $error("cla_pipe: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  cla_stage_t       stage_q [STAGES];
  cla_stage_t       stage_d [STAGES];
  logic [STAGES:0]  rdy;

  // Inputs seen by each stage: the ports for stage 0, else the previous register.
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  logic [8:1] grp_c   [NG];
  logic       grp_gg  [NG];
  logic       grp_gp  [NG];
  logic [7:0] grp_sum [NG];

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef CLA_PIPE_SUB_EN
  // a - b as a + ~b + 1; the external carry-in is ignored when subtracting.
  assign b_eff   = in_sub_i ? ~in_b_i : in_b_i;
  assign cin_eff = in_sub_i | in_cin_i;
`else
  assign b_eff   = in_b_i;
  assign cin_eff = in_cin_i;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : gen_src
    if (k == 0) begin : gen_head
      assign src_a[k]   = in_a_i;
      assign src_b[k]   = b_eff;
      assign src_sum[k] = '0;
      assign src_c[k]   = cin_eff;
      assign src_v[k]   = in_valid_i;
    end else begin : gen_body
      assign src_a[k]   = stage_q[k-1].a[WIDTH-1:0];
      assign src_b[k]   = stage_q[k-1].b[WIDTH-1:0];
      assign src_sum[k] = stage_q[k-1].sum[WIDTH-1:0];
      assign src_c[k]   = stage_q[k-1].carry;
      assign src_v[k]   = stage_q[k-1].valid;
    end
  end

  for (genvar j = 0; j < NG; j++) begin : gen_grp
    localparam int unsigned K = j / GPS;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin;

    assign a8 = src_a[K][j*GROUP_W +: GROUP_W];
    assign b8 = src_b[K][j*GROUP_W +: GROUP_W];

    if (j % GPS == 0) begin : gen_first
      assign cin = src_c[K];
    end else begin : gen_chain
      // Carry ripples from the previous group inside the same stage.
      assign cin = grp_gg[j-1] | (grp_gp[j-1] & gen_grp[j-1].cin);
    end

    cla_group8 u_group (
      .g_i   (a8 & b8),
      .p_i   (a8 | b8),
      .cin_i (cin),
      .c_o   (grp_c[j]),
      .gg_o  (grp_gg[j]),
      .gp_o  (grp_gp[j])
    );

    assign grp_sum[j] = a8 ^ b8 ^ {grp_c[j][7:1], cin};
  end

  // Backward ready chain; an empty stage accepts even when downstream stalls.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready_i;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      rdy[k] = !stage_q[k].valid || rdy[k+1];
    end
  end

  // Stage next-state: load on upstream valid and ready, otherwise hold data.
  always_comb begin
    stage_d = stage_q;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (rdy[k]) begin
        stage_d[k].valid = src_v[k];
      end
      if (src_v[k] && rdy[k]) begin
        stage_d[k].a[WIDTH-1:0]   = src_a[k];
        stage_d[k].b[WIDTH-1:0]   = src_b[k];
        stage_d[k].sum[WIDTH-1:0] = src_sum[k];
        for (int g = 0; g < int'(GPS); g++) begin
          stage_d[k].sum[(k*GPS+g)*GROUP_W +: GROUP_W] = grp_sum[k*GPS+g];
        end
        stage_d[k].carry = grp_c[(k+1)*GPS-1][8];
        stage_d[k].msb_c = grp_c[(k+1)*GPS-1][7];
      end
    end
  end

  // Pipeline registers; reset clears valids and data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign in_ready_o  = rdy[0];
  assign out_valid_o = stage_q[STAGES-1].valid;
  assign out_sum_o   = stage_q[STAGES-1].sum[WIDTH-1:0];
  assign out_cout_o  = stage_q[STAGES-1].carry;
  assign out_ovf_o   = stage_q[STAGES-1].carry ^ stage_q[STAGES-1].msb_c;

endmodule

// File: tb/tb_cla_pipe.sv
// Self-checking bench for cla_pipe (WIDTH=32, STAGES=2): table vectors,
// latency, backpressure, mid-flight reset, optional subtract, random sweep.
module tb_cla_pipe;

  localparam int unsigned W = 32;
  localparam int unsigned S = 2;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
`ifdef CLA_PIPE_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rnd_ready = 1'b0;

  always #10 clk = ~clk;

  cla_pipe #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_cin_i    (in_cin),
`ifdef CLA_PIPE_SUB_EN
    .in_sub_i    (in_sub),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_cout_o  (out_cout),
    .out_ovf_o   (out_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: plain wide addition; overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0]   t;
    logic [W-1:0] bb;
    logic         cc;
    res_t         r;
    bb     = sub ? ~b : b;
    cc     = sub ? 1'b1 : cin;
    t      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  function automatic vec_t mkv(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic [W-1:0] sum, input logic cout, input logic ovf);
    vec_t v;
    v.a        = a;
    v.b        = b;
    v.cin      = cin;
    v.exp.sum  = sum;
    v.exp.cout = cout;
    v.exp.ovf  = ovf;
    return v;
  endfunction

  // Present one operand set and hold it until accepted; record expectation.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input res_t e);
    bit acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    for (int t = 0; t < 200 && !acc; t++) begin
      #4;
      acc = in_ready;
      @(posedge clk);
      if (acc) sb.push_back(e);
      else     @(negedge clk);
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  // Drop in_valid and scramble operands, which must have no effect.
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cin   = 1'(($urandom) & 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor, sampled well before the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #6;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stray_output: got sum %h, required no output", out_sum);
        end else begin
          check(out_ready ? "result" : "held_result", {out_sum, out_cout, out_ovf}, sb[0]);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    logic [W-1:0] ra, rb;
    logic         rc;

    tbl[0] = mkv(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    tbl[1] = mkv(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    tbl[2] = mkv(32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0);
    tbl[3] = mkv(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    tbl[4] = mkv(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    tbl[5] = mkv(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    tbl[6] = mkv(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
    tbl[7] = mkv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tbl[8] = mkv(32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
    tbl[9] = mkv(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // Reset state
    #1 rst_n = 1'b0;
    #4;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_sum", 64'(out_sum), 64'd0);
    check("reset_out_cout", 64'(out_cout), 64'd0);
    check("reset_out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2 check("reset_in_ready", 64'(in_ready), 64'd1);

    // First add: result appears exactly S cycles after acceptance
    send(tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].exp);
    idle();
    #6 check("latency_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    #6 check("latency_valid", 64'(out_valid), 64'd1);

    // Remaining table vectors streamed back to back
    for (int i = 1; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp);
    idle();
    drain();

    // Backpressure: 4 back-to-back adds, out_ready low for 3 cycles
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          ra = 32'h1111_1111 * (i + 1);
          rb = 32'hF000_000F + i;
          send(ra, rb, 1'(i & 1), model(ra, rb, 1'(i & 1), 1'b0));
        end
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        #5;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two adds in flight
    @(negedge clk);
    out_ready = 1'b0;
    send(32'hAAAA_0000, 32'h0000_5555, 1'b0, model(32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0));
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, model(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0));
    idle();
    #1 check("flight_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out_sum", 64'(out_sum), 64'd0);
    check("midreset_out_cout", 64'(out_cout), 64'd0);
    sb.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    check("postreset_out_valid", 64'(out_valid), 64'd0);
    check("postreset_in_ready", 64'(in_ready), 64'd1);

`ifdef CLA_PIPE_SUB_EN
    // Subtraction
    in_sub = 1'b1;
    send(32'h0000_0005, 32'h0000_0007, 1'b0, model(32'h5, 32'h7, 1'b0, 1'b1));
    send(32'h8000_0000, 32'h0000_0001, 1'b0, model(32'h8000_0000, 32'h1, 1'b0, 1'b1));
    idle();
    in_sub = 1'b0;
    drain();
    check("sub_model_a", {32'd0, model(32'h5, 32'h7, 1'b0, 1'b1).sum}, 64'hFFFF_FFFE);
`endif

    // Random sweep with random valid gaps and random out_ready
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i % 7 == 0) ra = 32'hFFFF_FFFF;
      if (i % 11 == 0) rb = 32'h7FFF_FFFF;
      send(ra, rb, rc, model(ra, rb, rc, 1'b0));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rnd_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
